// File: rtl/fwd_regfile.sv
// Register file with in-flight forwarding and load-use stall detection.
// Optional macro FWD_REGFILE_BYPASS_EN enables forwarding; without it any pending writer stalls the reader.
module fwd_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NFWD   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_we,
  input  logic [ADDR_W-1:0]      wb_waddr,
  input  logic [DATA_W-1:0]      wb_wdata,
  input  logic [NFWD-1:0]        fwd_we,
  input  logic [NFWD-1:0]        fwd_rdy,
  input  logic [NFWD*ADDR_W-1:0] fwd_waddr,
  input  logic [NFWD*DATA_W-1:0] fwd_wdata,
  input  logic [NRD-1:0]         rd_en,
  input  logic [NRD*ADDR_W-1:0]  rd_addr,
  output logic [NRD*DATA_W-1:0]  rd_data,
  output logic                   stall,
  input  logic                   cnt_clr,
  output logic [15:0]            stall_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] sel;
  logic              hit;
  logic              pend;

  // Entry 0 is cleared by reset and never written, so it always holds zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (wb_we && wb_waddr != '0) begin
      mem[wb_waddr] <= wb_wdata;
    end
  end

  // Per port, the youngest matching writer wins; its readiness alone decides the stall.
  always_comb begin
    rd_data = '0;
    stall   = 1'b0;
    addr    = '0;
    sel     = '0;
    hit     = 1'b0;
    pend    = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      addr = rd_addr[p*ADDR_W +: ADDR_W];
      sel  = mem[addr];
      hit  = 1'b0;
      pend = 1'b0;
      for (int i = 0; i < NFWD; i++) begin
        if (!hit && fwd_we[i] && fwd_waddr[i*ADDR_W +: ADDR_W] == addr) begin
          hit = 1'b1;
`ifdef FWD_REGFILE_BYPASS_EN
          sel  = fwd_wdata[i*DATA_W +: DATA_W];
          pend = !fwd_rdy[i];
`else
          pend = 1'b1;
`endif
        end
      end
      if (!hit && wb_we && wb_waddr == addr) begin
        hit = 1'b1;
`ifdef FWD_REGFILE_BYPASS_EN
        sel = wb_wdata;
`else
        pend = 1'b1;
`endif
      end
      if (rst && rd_en[p] && addr != '0) begin
        rd_data[p*DATA_W +: DATA_W] = sel;
        if (pend) stall = 1'b1;
      end
    end
  end

`ifndef FWD_REGFILE_BYPASS_EN
  // Forwarded data and readiness are not consulted when bypassing is off.
  logic unused_nobyp;
  assign unused_nobyp = ^{fwd_rdy, fwd_wdata};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_regfile.sv
// Self-checking bench for fwd_regfile: vector table, directed hazard sequences, random vs. a reference model.
module tb_fwd_regfile;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NRD = 2;
  localparam int NFWD = 2;
  localparam int DEPTH = 1 << AW;
`ifdef FWD_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wb_we = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;
  logic [NFWD-1:0] fwe = '0;
  logic [NFWD-1:0] frdy = '0;
  logic [AW-1:0] fa [NFWD];
  logic [DW-1:0] fd [NFWD];
  logic [NRD-1:0] ren = '0;
  logic [AW-1:0] ra [NRD];
  logic cnt_clr = 1'b0;
  logic [NFWD*AW-1:0] fwd_waddr;
  logic [NFWD*DW-1:0] fwd_wdata;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic stall;
  logic [15:0] stall_cnt;

  assign fwd_waddr = {fa[1], fa[0]};
  assign fwd_wdata = {fd[1], fd[0]};
  assign rd_addr   = {ra[1], ra[0]};

  always #5 clk = ~clk;

  fwd_regfile #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .NFWD(NFWD)) dut (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_waddr(wa), .wb_wdata(wd),
    .fwd_we(fwe), .fwd_rdy(frdy), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .rd_en(ren), .rd_addr(rd_addr), .rd_data(rd_data), .stall(stall),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: array contents, stall counter, and writer lists ordered youngest-first.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic r; } cand_t;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [15:0] ref_cnt = '0;
  logic [DW-1:0] exp_rd [NRD];
  logic exp_stall;

  function automatic void model_eval();
    cand_t q[$];
    int idx[$];
    exp_stall = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      exp_rd[p] = '0;
      if (!rst || !ren[p] || ra[p] == '0) continue;
      q.delete();
      for (int i = 0; i < NFWD; i++)
        if (fwe[i]) q.push_back('{a: fa[i], d: fd[i], r: frdy[i]});
      if (wb_we) q.push_back('{a: wa, d: wd, r: 1'b1});
      idx = q.find_first_index(item) with (item.a == ra[p]);
      if (BYP) begin
        if (idx.size() == 0) exp_rd[p] = ref_mem[ra[p]];
        else begin
          exp_rd[p] = q[idx[0]].d;
          if (!q[idx[0]].r) exp_stall = 1'b1;
        end
      end else begin
        exp_rd[p] = ref_mem[ra[p]];
        if (idx.size() != 0) exp_stall = 1'b1;
      end
    end
  endfunction

  function automatic void model_update();
    if (rst && wb_we && wa != '0) ref_mem[wa] = wd;
    if (cnt_clr) ref_cnt = '0;
    else if (exp_stall && ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
  endfunction

  task automatic idle();
    wb_we = 1'b0; wa = '0; wd = '0; fwe = '0; frdy = '0; ren = '0; cnt_clr = 1'b0;
    for (int i = 0; i < NFWD; i++) begin fa[i] = '0; fd[i] = '0; end
    for (int p = 0; p < NRD; p++) ra[p] = '0;
  endtask

  task automatic compare_all(input string tag);
    model_eval();
    for (int p = 0; p < NRD; p++)
      chk($sformatf("%s rd%0d", tag, p), rd_data[p*DW +: DW], exp_rd[p]);
    chk({tag, " stall"}, {31'd0, stall}, {31'd0, exp_stall});
    chk({tag, " stall_cnt"}, {16'd0, stall_cnt}, {16'd0, ref_cnt});
  endtask

  // Called right after inputs are driven following a falling edge.
  task automatic tick_check(input string tag);
    #1;
    compare_all(tag);
    @(posedge clk);
    model_update();
  endtask

  typedef struct {
    logic [1:0] fwe, frdy; logic [AW-1:0] fa0, fa1; logic [DW-1:0] fd0, fd1;
    logic wwe; logic [AW-1:0] wa; logic [DW-1:0] wd;
    logic [1:0] ren; logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] e0, e1; logic es;
  } vec_t;
  vec_t tbl [11];

  initial begin
    // Array preloaded with r1=0x11, r2=0x22, r3=0x33 before the table is applied.
    tbl[0]  = '{2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 2'b11, 5'd1, 5'd2,
                32'h11, 32'h22, 1'b0};
    tbl[1]  = '{2'b11, 2'b11, 5'd1, 5'd1, 32'h333, 32'h222, 1'b1, 5'd1, 32'h111, 2'b11, 5'd1, 5'd2,
                BYP ? 32'h333 : 32'h11, 32'h22, !BYP};
    tbl[2]  = '{2'b10, 2'b11, 5'd2, 5'd1, 32'h333, 32'h222, 1'b0, 5'd0, 32'h0, 2'b01, 5'd1, 5'd0,
                BYP ? 32'h222 : 32'h11, 32'h0, !BYP};
    tbl[3]  = '{2'b00, 2'b00, 5'd2, 5'd2, 32'h0, 32'h0, 1'b1, 5'd2, 32'h999, 2'b10, 5'd0, 5'd2,
                32'h0, BYP ? 32'h999 : 32'h22, !BYP};
    tbl[4]  = '{2'b11, 2'b10, 5'd2, 5'd2, 32'hAA, 32'h55, 1'b0, 5'd0, 32'h0, 2'b01, 5'd2, 5'd0,
                BYP ? 32'hAA : 32'h22, 32'h0, 1'b1};
    tbl[5]  = '{2'b11, 2'b01, 5'd2, 5'd2, 32'hAA, 32'h55, 1'b0, 5'd0, 32'h0, 2'b01, 5'd2, 5'd0,
                BYP ? 32'hAA : 32'h22, 32'h0, !BYP};
    tbl[6]  = '{2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 2'b01, 5'd0, 5'd1,
                32'h0, 32'h0, 1'b0};
    tbl[7]  = '{2'b01, 2'b00, 5'd1, 5'd0, 32'hBB, 32'h0, 1'b0, 5'd0, 32'h0, 2'b00, 5'd1, 5'd1,
                32'h0, 32'h0, 1'b0};
    tbl[8]  = '{2'b00, 2'b00, 5'd1, 5'd1, 32'hBB, 32'hCC, 1'b0, 5'd0, 32'h0, 2'b01, 5'd1, 5'd0,
                32'h11, 32'h0, 1'b0};
    tbl[9]  = '{2'b01, 2'b00, 5'd0, 5'd0, 32'hBB, 32'h0, 1'b0, 5'd0, 32'h0, 2'b01, 5'd0, 5'd0,
                32'h0, 32'h0, 1'b0};
    tbl[10] = '{2'b01, 2'b00, 5'd3, 5'd0, 32'hDD, 32'h0, 1'b0, 5'd0, 32'h0, 2'b11, 5'd1, 5'd3,
                32'h11, BYP ? 32'hDD : 32'h33, 1'b1};
  end

  initial begin
    idle();
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;

    // Reset: outputs forced to zero and writes ignored even with a pending hazard.
    rst = 1'b0;
    #1;
    wb_we = 1'b1; wa = 5'd1; wd = 32'hDEAD; ren = 2'b11; ra[0] = 5'd1; ra[1] = 5'd2;
    fwe = 2'b01; frdy = 2'b00; fa[0] = 5'd2;
    @(posedge clk); @(negedge clk);
    chk("reset rd_data", rd_data[DW-1:0] | rd_data[2*DW-1:DW], 32'h0);
    chk("reset stall", {31'd0, stall}, 32'h0);
    chk("reset stall_cnt", {16'd0, stall_cnt}, 32'h0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    ren = 2'b01; ra[0] = 5'd1;
    #1 chk("write ignored in reset", rd_data[DW-1:0], 32'h0);

    // Write-back then read on the following cycle.
    @(negedge clk); idle(); wb_we = 1'b1; wa = 5'd1; wd = 32'h11;
    tick_check("wb r1");
    @(negedge clk); idle(); ren = 2'b01; ra[0] = 5'd1;
    #1;
    chk("read r1 data", rd_data[DW-1:0], 32'h11);
    chk("read r1 stall", {31'd0, stall}, 32'h0);
    @(posedge clk); model_eval(); model_update();
    @(negedge clk); idle(); wb_we = 1'b1; wa = 5'd2; wd = 32'h22; tick_check("wb r2");
    @(negedge clk); idle(); wb_we = 1'b1; wa = 5'd3; wd = 32'h33; tick_check("wb r3");

    // Combinational vector table; inputs withdrawn before the next rising edge.
    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      fwe = tbl[v].fwe; frdy = tbl[v].frdy; fa[0] = tbl[v].fa0; fa[1] = tbl[v].fa1;
      fd[0] = tbl[v].fd0; fd[1] = tbl[v].fd1; wb_we = tbl[v].wwe; wa = tbl[v].wa; wd = tbl[v].wd;
      ren = tbl[v].ren; ra[0] = tbl[v].ra0; ra[1] = tbl[v].ra1;
      #1;
      chk($sformatf("vec%0d rd0", v), rd_data[DW-1:0], tbl[v].e0);
      chk($sformatf("vec%0d rd1", v), rd_data[2*DW-1:DW], tbl[v].e1);
      chk($sformatf("vec%0d stall", v), {31'd0, stall}, {31'd0, tbl[v].es});
      #1 idle();
    end

    // Unready youngest writer: three stalled edges, then a clear that beats the increment.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); idle();
      fwe = 2'b11; frdy = 2'b10; fa[0] = 5'd2; fa[1] = 5'd2; fd[0] = 32'hAA; fd[1] = 32'h55;
      ren = 2'b01; ra[0] = 5'd2;
      cnt_clr = (c == 0 || c == 4);
      if (c == 4) #1 chk("cnt after 3 stalls", {16'd0, stall_cnt}, 32'd3);
      tick_check($sformatf("load-use c%0d", c));
    end
    @(negedge clk); idle();
    #1 chk("cnt after clear", {16'd0, stall_cnt}, 32'd0);

    // Write-back pending on the read address, then the same read after it retires.
    @(negedge clk); idle(); wb_we = 1'b1; wa = 5'd3; wd = 32'h7; ren = 2'b01; ra[0] = 5'd3;
    #1;
    chk("wb pending stall", {31'd0, stall}, {31'd0, !BYP});
    chk("wb pending data", rd_data[DW-1:0], BYP ? 32'h7 : 32'h33);
    tick_check("wb pending");
    @(negedge clk); idle(); ren = 2'b01; ra[0] = 5'd3;
    #1;
    chk("wb retired data", rd_data[DW-1:0], 32'h7);
    chk("wb retired stall", {31'd0, stall}, 32'h0);
    tick_check("wb retired");

    // Random traffic over a small address range so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      wb_we = 1'($urandom_range(0, 1)); wa = AW'($urandom_range(0, 3)); wd = $urandom;
      fwe = NFWD'($urandom_range(0, 3)); frdy = NFWD'($urandom_range(0, 3));
      for (int i = 0; i < NFWD; i++) begin fa[i] = AW'($urandom_range(0, 3)); fd[i] = $urandom; end
      ren = NRD'($urandom_range(0, 3));
      for (int p = 0; p < NRD; p++) ra[p] = AW'($urandom_range(0, 3));
      cnt_clr = ($urandom_range(0, 15) == 0);
      tick_check($sformatf("rand%0d", n));
    end

    // Saturation of the stall counter, then an asynchronous reset between edges.
    @(negedge clk); idle();
    fwe = 2'b01; frdy = 2'b00; fa[0] = 5'd2; fd[0] = 32'hEE; ren = 2'b01; ra[0] = 5'd2; cnt_clr = 1'b1;
    tick_check("sat clear");
    @(negedge clk); cnt_clr = 1'b0;
    for (int n = 0; n < 65534; n++) @(posedge clk);
    @(negedge clk);
    chk("cnt near saturation", {16'd0, stall_cnt}, 32'h0000FFFE);
    for (int n = 0; n < 6; n++) @(posedge clk);
    @(negedge clk);
    chk("cnt saturated", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("stall held", {31'd0, stall}, 32'h1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async reset cnt", {16'd0, stall_cnt}, 32'h0);
    chk("async reset stall", {31'd0, stall}, 32'h0);
    chk("async reset rd", rd_data[DW-1:0], 32'h0);
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
    ref_cnt = '0;
    @(negedge clk); idle(); rst = 1'b1; ren = 2'b11; ra[0] = 5'd3; ra[1] = 5'd1;
    tick_check("after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fwd_regfile.md
FWD_REGFILE -- requirements
Module: fwd_regfile

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter NFWD, default 2, number of in-flight forwarding sources; index 0 is the youngest stage (EX), index NFWD-1 the oldest before write-back.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 wb_we  in  1  write-back write enable.
REQ-009 wb_waddr  in  ADDR_W  write-back destination register.
REQ-010 wb_wdata  in  DATA_W  write-back data.
REQ-011 fwd_we  in  NFWD  per-stage "will write a register" flag.
REQ-012 fwd_rdy  in  NFWD  per-stage "fwd_wdata is final" flag; low for a load still in flight.
REQ-013 fwd_waddr  in  NFWD*ADDR_W  packed per-stage destination; slice i at [i*ADDR_W +: ADDR_W].
REQ-014 fwd_wdata  in  NFWD*DATA_W  packed per-stage data.
REQ-015 rd_en  in  NRD  per-port read enable.
REQ-016 rd_addr  in  NRD*ADDR_W  packed read addresses.
REQ-017 rd_data  out  NRD*DATA_W  packed read data, combinational.
REQ-018 stall  out  1  hazard: pipeline must hold the reading stage this cycle.
REQ-019 cnt_clr  in  1  synchronous clear of stall_cnt.
REQ-020 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-021 Register 0 SHALL read as zero and SHALL never be written.
REQ-022 On a rising edge with rst high, wb_we=1 and wb_waddr!=0, the array entry SHALL take wb_wdata.
REQ-023 Per port p: if rst low, rd_en[p]=0 or rd_addr[p]=0, rd_data[p] SHALL be zero.
REQ-024 Otherwise rd_data[p] SHALL be the lowest-index stage i with fwd_we[i]=1 and fwd_waddr[i]=rd_addr[p]; else wb_wdata when wb_we=1 and wb_waddr matches; else the array entry.
REQ-025 Only the highest-priority match SHALL be considered; older matching stages are ignored even if ready.
REQ-026 stall SHALL be 1 when any enabled port with non-zero address has its highest-priority match at a stage with fwd_rdy=0; otherwise 0.
REQ-027 rd_data SHALL remain defined (the unready stage's fwd_wdata) while stall=1; the consumer discards it.
REQ-028 stall_cnt SHALL increment by 1 on each rising edge where stall=1, saturate at 16'hFFFF, and hold otherwise.
REQ-029 cnt_clr=1 SHALL load stall_cnt with zero, taking priority over a simultaneous increment.
REQ-030 All parameter-derived widths SHALL be computed from the parameters; no hard-coded 32 or 5.

Reset
REQ-031 rst low SHALL asynchronously clear all array entries and stall_cnt to zero.
REQ-032 While rst is low, rd_data SHALL be all zero, stall SHALL be 0, and writes SHALL be ignored.
REQ-033 A reset asserted mid-stall SHALL drop stall within the same cycle. The first edge after release SHALL be a normal edge.

Configuration
REQ-034 Macro FWD_REGFILE_BYPASS_EN defined: forwarding per REQ-024..REQ-026.
REQ-035 Macro absent: rd_data SHALL come from the array only (zero rules kept). stall SHALL be 1 when any enabled non-zero port matches any stage with fwd_we=1, or wb_we=1 with a matching wb_waddr, regardless of fwd_rdy. stall_cnt behaviour is unchanged.

Verification
REQ-036 Reset, then write r1=0x11 via wb; next cycle read r1 on port 0 -> 0x00000011, stall=0.
REQ-037 fwd0 (we,rdy, r1, 0x33) and fwd1 (we,rdy, r1, 0x22) together with wb r1=0x11; read r1 -> 0x33 (bypass build).
REQ-038 fwd0 (we, rdy=0, r2) and fwd1 (we,rdy, r2, 0x55); read r2 -> stall=1; three such cycles -> stall_cnt=3; cnt_clr with stall=1 -> stall_cnt=0.
REQ-039 wb_we=1, waddr=0, data 0xFFFFFFFF; read r0 -> 0, stall=0.
REQ-040 Drive stall=1 for 65540 cycles -> stall_cnt=0xFFFF; assert rst mid-run -> stall_cnt=0 and stall=0 with no clock edge.
REQ-041 Bypass-disabled build: wb r3=0x7 pending, read r3 -> stall=1; next cycle with wb_we=0 -> 0x7, stall=0.
